// File: rtl/comp_pkg.sv
// Shared types and sizing helpers for the serial magnitude comparator.
package comp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Number of chunks compared per operation.
  function automatic int unsigned nchunk(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

  // Ceiling log2; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

  // Chunk index width, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (clog2(n) > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/comp_nb_serial_if.sv
// Request/result bundle between a requester and the serial comparator.
interface comp_nb_serial_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_mode;
  logic             busy;
  logic             done;
  logic             eq;
  logic             gt;
  logic             lt;

  modport master (
    output start, a, b, signed_mode,
    input  busy, done, eq, gt, lt
  );

  modport slave (
    input  start, a, b, signed_mode,
    output busy, done, eq, gt, lt
  );
endinterface

// File: rtl/comp_chunk.sv
// Combinational CHUNK-bit unsigned comparator (wide form of the XNOR equality cell).
module comp_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  output logic             eq_o,
  output logic             gt_o
);

  // Equality is the AND of per-bit XNORs; magnitude is a plain unsigned compare.
  assign eq_o = ~|(a_i ^ b_i);
  assign gt_o = (a_i > b_i);

endmodule

// File: rtl/comp_nb_serial.sv
// Multi-cycle magnitude comparator: walks the operands MSB chunk first.
module comp_nb_serial
  import comp_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned CHUNK      = 4,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  comp_nb_serial_if.slave bus
);

  localparam int unsigned      NCHUNK   = nchunk(WIDTH, CHUNK);
  localparam int unsigned      IDXW     = idx_width(NCHUNK);
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);
  localparam logic [IDXW-1:0]  IDX_TOP  = IDXW'(NCHUNK - 1);

  state_t           state_q;
  logic [IDXW-1:0]  idx_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             decided_q;
  logic             busy_q;
  logic             done_q;
  logic             eq_q;
  logic             gt_q;
  logic             lt_q;

  logic [CHUNK-1:0] a_chunks [NCHUNK];
  logic [CHUNK-1:0] b_chunks [NCHUNK];
  logic             chunk_eq_c;
  logic             chunk_gt_c;
  logic             first_diff_c;
  logic             last_c;

  // Slice the latched operands into chunk lanes for the index mux.
  for (genvar g = 0; g < NCHUNK; g++) begin : g_split
    assign a_chunks[g] = a_q[g*CHUNK +: CHUNK];
    assign b_chunks[g] = b_q[g*CHUNK +: CHUNK];
  end

  comp_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a_i  (a_chunks[idx_q]),
    .b_i  (b_chunks[idx_q]),
    .eq_o (chunk_eq_c),
    .gt_o (chunk_gt_c)
  );

  assign first_diff_c = !chunk_eq_c && !decided_q;
  assign last_c       = (idx_q == '0);

  // Control FSM with operand, index and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      decided_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      eq_q      <= 1'b0;
      gt_q      <= 1'b0;
      lt_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            // Flipping the sign bit maps two's complement onto offset binary,
            // so the unsigned chunk walk yields the signed ordering.
            a_q       <= bus.a ^ (bus.signed_mode ? MSB_MASK : '0);
            b_q       <= bus.b ^ (bus.signed_mode ? MSB_MASK : '0);
            eq_q      <= 1'b0;
            gt_q      <= 1'b0;
            lt_q      <= 1'b0;
            decided_q <= 1'b0;
            idx_q     <= IDX_TOP;
            busy_q    <= 1'b1;
            state_q   <= RUN;
          end
        end
        RUN: begin
          // Only the most significant difference determines the result.
          if (first_diff_c) begin
            gt_q      <= chunk_gt_c;
            lt_q      <= !chunk_gt_c;
            decided_q <= 1'b1;
          end
          if (last_c || (first_diff_c && EARLY_EXIT)) begin
            eq_q    <= !decided_q && chunk_eq_c;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            idx_q <= idx_q - IDXW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.eq   = eq_q;
  assign bus.gt   = gt_q;
  assign bus.lt   = lt_q;

endmodule

// File: tb/tb_comp_nb_serial.sv
// Bench for comp_nb_serial: three instances (16/4 early exit, 16/4 full walk, 8/8).
module tb_comp_nb_serial;

  logic clk;
  logic rst_n;

  comp_nb_serial_if #(.WIDTH(16)) if0 ();
  comp_nb_serial_if #(.WIDTH(16)) if1 ();
  comp_nb_serial_if #(.WIDTH(8))  if2 ();

  comp_nb_serial #(.WIDTH(16), .CHUNK(4), .EARLY_EXIT(1'b1)) u_ee (
    .clk(clk), .rst_n(rst_n), .bus(if0)
  );
  comp_nb_serial #(.WIDTH(16), .CHUNK(4), .EARLY_EXIT(1'b0)) u_full (
    .clk(clk), .rst_n(rst_n), .bus(if1)
  );
  comp_nb_serial #(.WIDTH(8), .CHUNK(8), .EARLY_EXIT(1'b1)) u_w8 (
    .clk(clk), .rst_n(rst_n), .bus(if2)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          sel;
    logic [15:0] a;
    logic [15:0] b;
    logic        sm;
    logic [2:0]  res;   // {eq, gt, lt}
    int          lat;
    string       name;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic st, input logic [15:0] a,
                       input logic [15:0] b, input logic sm);
    case (sel)
      0: begin if0.start = st; if0.a = a; if0.b = b; if0.signed_mode = sm; end
      1: begin if1.start = st; if1.a = a; if1.b = b; if1.signed_mode = sm; end
      default: begin if2.start = st; if2.a = a[7:0]; if2.b = b[7:0]; if2.signed_mode = sm; end
    endcase
  endtask

  // {busy, done, eq, gt, lt}
  function automatic logic [4:0] outs(input int sel);
    case (sel)
      0:       return {if0.busy, if0.done, if0.eq, if0.gt, if0.lt};
      1:       return {if1.busy, if1.done, if1.eq, if1.gt, if1.lt};
      default: return {if2.busy, if2.done, if2.eq, if2.gt, if2.lt};
    endcase
  endfunction

  // Reference: integer compare plus "first differing chunk from the top" latency.
  task automatic model(input int sel, input logic [15:0] a, input logic [15:0] b,
                       input logic sm, output logic [2:0] res, output int lat);
    int w, c, nch, first, ua, ub, sa, sb, cm;
    bit found;
    w  = (sel == 2) ? 8 : 16;
    c  = (sel == 2) ? 8 : 4;
    ua = int'(a) & ((1 << w) - 1);
    ub = int'(b) & ((1 << w) - 1);
    sa = ua;
    sb = ub;
    if (sm && ((ua >> (w - 1)) & 1) == 1) sa = ua - (1 << w);
    if (sm && ((ub >> (w - 1)) & 1) == 1) sb = ub - (1 << w);
    res = (sa == sb) ? 3'b100 : ((sa > sb) ? 3'b010 : 3'b001);
    nch   = w / c;
    cm    = (1 << c) - 1;
    first = nch;
    found = 1'b0;
    for (int i = nch - 1; i >= 0; i--) begin
      if (!found && (((ua >> (i * c)) & cm) != ((ub >> (i * c)) & cm))) begin
        first = nch - i;
        found = 1'b1;
      end
    end
    lat = (sel == 1) ? nch : first;
  endtask

  // One full transaction: start, count cycles to done, check results and hold.
  task automatic run_cmp(input int sel, input logic [15:0] a, input logic [15:0] b,
                         input logic sm, input logic [2:0] exp_r, input int exp_lat,
                         input string name);
    logic [4:0] o;
    int lat;
    bit seen;
    drive(sel, 1'b1, a, b, sm);
    @(posedge clk); #1;
    drive(sel, 1'b0, 16'h0, 16'h0, 1'b0);
    o = outs(sel);
    check({name, " busy_at_accept"}, int'(o[4]), 1);
    check({name, " cleared_at_accept"}, int'(o[2:0]), 0);
    lat  = 0;
    seen = 1'b0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(posedge clk); #1;
      o = outs(sel);
      if (o[3]) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    check({name, " done_seen"}, int'(seen), 1);
    check({name, " latency"}, lat, exp_lat);
    check({name, " result"}, int'(o[2:0]), int'(exp_r));
    check({name, " busy_at_done"}, int'(o[4]), 0);
    @(posedge clk); #1;
    o = outs(sel);
    check({name, " done_pulse_width"}, int'(o[3]), 0);
    check({name, " result_held"}, int'(o[2:0]), int'(exp_r));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[$];
    logic [4:0] o;
    logic [2:0] r;
    int lat, dones;
    logic [15:0] ra, rb;
    logic rsm;
    int rsel;

    clk   = 1'b0;
    rst_n = 1'b0;
    for (int s = 0; s < 3; s++) drive(s, 1'b0, 16'h0, 16'h0, 1'b0);
    #2;
    for (int s = 0; s < 3; s++) check($sformatf("reset_outputs_%0d", s), int'(outs(s)), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    vecs.push_back('{0, 16'h1234, 16'h1234, 1'b0, 3'b100, 4, "eq_1234"});
    vecs.push_back('{0, 16'h9000, 16'h1FFF, 1'b0, 3'b010, 1, "ee_unsigned_gt"});
    vecs.push_back('{1, 16'h9000, 16'h1FFF, 1'b0, 3'b010, 4, "full_unsigned_gt"});
    vecs.push_back('{0, 16'h9000, 16'h1FFF, 1'b1, 3'b001, 1, "ee_signed_lt"});
    vecs.push_back('{0, 16'hFFFF, 16'h0000, 1'b1, 3'b001, 1, "neg1_vs_0_signed"});
    vecs.push_back('{0, 16'hFFFF, 16'h0000, 1'b0, 3'b010, 1, "ffff_vs_0_unsigned"});
    vecs.push_back('{2, 16'h007F, 16'h0080, 1'b1, 3'b010, 1, "w8_signed_gt"});
    vecs.push_back('{2, 16'h007F, 16'h0080, 1'b0, 3'b001, 1, "w8_unsigned_lt"});
    vecs.push_back('{2, 16'h00A5, 16'h00A5, 1'b1, 3'b100, 1, "w8_eq"});
    vecs.push_back('{0, 16'h0005, 16'h0006, 1'b0, 3'b001, 4, "lsb_chunk_lt"});
    vecs.push_back('{1, 16'h12F0, 16'h1301, 1'b0, 3'b001, 4, "full_first_diff_wins"});
    vecs.push_back('{0, 16'h12F0, 16'h1301, 1'b0, 3'b001, 2, "ee_second_chunk"});
    vecs.push_back('{1, 16'h8000, 16'h8000, 1'b1, 3'b100, 4, "full_min_eq_signed"});

    foreach (vecs[i])
      run_cmp(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].res, vecs[i].lat, vecs[i].name);

    // Start while busy is ignored; start in the done cycle is accepted.
    drive(0, 1'b1, 16'h0005, 16'h0006, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b1, 16'h0000, 16'h0000, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
    check("busy_ignore busy_e2", int'(outs(0) >> 4), 1);
    @(posedge clk); #1;
    check("busy_ignore no_done_e3", int'(outs(0) >> 3) & 1, 0);
    @(posedge clk); #1;
    o = outs(0);
    check("busy_ignore done_e4", int'(o[3]), 1);
    check("busy_ignore result_e4", int'(o[2:0]), 3'b001);
    drive(0, 1'b1, 16'h0000, 16'h0000, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
    o = outs(0);
    check("back_to_back busy", int'(o[4]), 1);
    check("back_to_back cleared", int'(o[3:0]), 0);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      o = outs(0);
      if (i < 4) check($sformatf("back_to_back no_done_%0d", i), int'(o[3]), 0);
      else begin
        check("back_to_back done", int'(o[3]), 1);
        check("back_to_back eq", int'(o[2:0]), 3'b100);
      end
    end

    // Asynchronous reset mid-compare discards the operation.
    drive(0, 1'b1, 16'h1234, 16'h1234, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset_mid busy_before", int'(outs(0) >> 4), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_mid outputs_async", int'(outs(0)), 0);
    #2;
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      o = outs(0);
      if (o[3] || o[4]) dones++;
    end
    check("reset_mid no_done_after", dones, 0);
    run_cmp(0, 16'h0001, 16'h0000, 1'b0, 3'b010, 4, "post_reset_gt");

    // Randomized traffic against the reference model.
    for (int i = 0; i < 60; i++) begin
      rsel = $urandom_range(0, 2);
      ra   = 16'($urandom);
      rsm  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = 16'($urandom);
        2:       rb = ra ^ (16'(1) << $urandom_range(0, 15));
        default: rb = ra ^ 16'($urandom_range(1, 15));
      endcase
      model(rsel, ra, rb, rsm, r, lat);
      run_cmp(rsel, ra, rb, rsm, r, lat, $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
